// File: rtl/score_pkg.sv
// Shared types and geometry defaults for the score digit renderer.
package score_pkg;

    localparam int DIGIT_W = 11;
    localparam int DIGIT_H = 16;
    localparam int GAP     = 2;

    localparam logic [9:0] DEFAULT_X0 = 10'd280;
    localparam logic [9:0] DEFAULT_Y0 = 10'd16;

    typedef logic [3:0] bcd_t;
    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam bcd_t BCD_NINE  = 4'd9;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score with saturation at 99 and clear-over-point priority.
module bcd_score_counter
    import score_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic point,
    input  logic clear,
    output bcd_t tens,
    output bcd_t ones,
    output logic max_reached
);

    bcd_t next_tens;
    bcd_t next_ones;
    logic at_max;

    assign at_max = (tens == BCD_NINE) && (ones == BCD_NINE);

    // Next score: clear beats point; a point at 99 is dropped.
    always_comb begin
        next_tens = tens;
        next_ones = ones;
        if (clear) begin
            next_tens = '0;
            next_ones = '0;
        end else if (point && !at_max) begin
            if (ones == BCD_NINE) begin
                next_ones = '0;
                next_tens = tens + 4'd1;
            end else begin
                next_ones = ones + 4'd1;
            end
        end
    end

    // Score and saturation flag register together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens        <= '0;
            ones        <= '0;
            max_reached <= 1'b0;
        end else begin
            tens        <= next_tens;
            ones        <= next_ones;
            max_reached <= (next_tens == BCD_NINE) && (next_ones == BCD_NINE);
        end
    end

endmodule

// File: rtl/score_renderer.sv
// Score digit renderer: maps screen coordinates into sprite ROM addresses
// and returns the composited score pixel two clocks later.
//
// Stream semantics: pixel_valid/rgb_valid form a valid-only stream with no
// backpressure. Every cycle's coordinate is accepted, and its pixel emerges
// exactly two clock edges later tagged with the delayed pixel_valid.
module score_renderer
    import score_pkg::*;
#(
    parameter logic [9:0] X0 = DEFAULT_X0,
    parameter logic [9:0] Y0 = DEFAULT_Y0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point,
    input  logic       clear,
    input  logic       frame_start,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pixel_valid,
    output logic [9:0] digit_row,
    output logic [9:0] digit_col,
    output logic [3:0] digit_sel,
    input  logic [2:0] digit_rgb,
    output logic [2:0] rgb_out,
    output logic       rgb_valid,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       max_reached
);

    localparam logic [9:0] TENS_L = X0;
    localparam logic [9:0] TENS_R = 10'(X0 + DIGIT_W);
    localparam logic [9:0] ONES_L = 10'(X0 + DIGIT_W + GAP);
    localparam logic [9:0] ONES_R = 10'(X0 + DIGIT_W + GAP + DIGIT_W);
    localparam logic [9:0] BOX_T  = Y0;
    localparam logic [9:0] BOX_B  = 10'(Y0 + DIGIT_H);

    bcd_t disp_tens;
    bcd_t disp_ones;
    logic in_rows;
    logic in_tens;
    logic in_ones;
    logic hit;
    logic valid_d1;

    bcd_score_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .point      (point),
        .clear      (clear),
        .tens       (tens),
        .ones       (ones),
        .max_reached(max_reached)
    );

    // Display copy only moves at frame start so a frame never tears; it
    // samples the registered score, so a same-cycle point is not yet visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_tens <= '0;
            disp_ones <= '0;
        end else if (frame_start) begin
            disp_tens <= tens;
            disp_ones <= ones;
        end
    end

    assign in_rows = (pixel_y >= BOX_T) && (pixel_y < BOX_B);
    assign in_tens = pixel_valid && in_rows && (pixel_x >= TENS_L) && (pixel_x < TENS_R);
    assign in_ones = pixel_valid && in_rows && (pixel_x >= ONES_L) && (pixel_x < ONES_R);

    // Stage 1: sprite address and hit flag; a zero tens digit is blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_row <= '0;
            digit_col <= '0;
            digit_sel <= '0;
            hit       <= 1'b0;
            valid_d1  <= 1'b0;
        end else begin
            valid_d1 <= pixel_valid;
            if (in_tens) begin
                digit_row <= pixel_y - BOX_T;
                digit_col <= pixel_x - TENS_L;
                digit_sel <= disp_tens;
                hit       <= (disp_tens != 4'd0);
            end else if (in_ones) begin
                digit_row <= pixel_y - BOX_T;
                digit_col <= pixel_x - ONES_L;
                digit_sel <= disp_ones;
                hit       <= 1'b1;
            end else begin
                digit_row <= '0;
                digit_col <= '0;
                digit_sel <= '0;
                hit       <= 1'b0;
            end
        end
    end

    // Stage 2: capture the combinational ROM return, black outside a digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= RGB_BLACK;
            rgb_valid <= 1'b0;
        end else begin
            rgb_out   <= hit ? digit_rgb : RGB_BLACK;
            rgb_valid <= valid_d1;
        end
    end

endmodule

// File: tb/tb_score_renderer.sv
// Directed bench for score_renderer with a behavioural digit ROM.
module tb_score_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       point;
    logic       clear;
    logic       frame_start;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pixel_valid;
    logic [9:0] digit_row;
    logic [9:0] digit_col;
    logic [3:0] digit_sel;
    logic [2:0] digit_rgb;
    logic [2:0] rgb_out;
    logic       rgb_valid;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       max_reached;

    int checks   = 0;
    int failures = 0;

    // Clock: 10 time units per pixel.
    always #5 clk = ~clk;

    // Sprite ROM stand-in: never returns black, so a missed hit is visible.
    function automatic logic [2:0] rom_model(input logic [3:0] s, input logic [9:0] r,
                                             input logic [9:0] c);
        int v;
        v = (int'(s) * 7 + int'(r) * 3 + int'(c)) % 7 + 1;
        return 3'(v);
    endfunction

    assign digit_rgb = rom_model(digit_sel, digit_row, digit_col);

    score_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .point      (point),
        .clear      (clear),
        .frame_start(frame_start),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_valid(pixel_valid),
        .digit_row  (digit_row),
        .digit_col  (digit_col),
        .digit_sel  (digit_sel),
        .digit_rgb  (digit_rgb),
        .rgb_out    (rgb_out),
        .rgb_valid  (rgb_valid),
        .tens       (tens),
        .ones       (ones),
        .max_reached(max_reached)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_point();
        point = 1'b1;
        tick();
        point = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        pixel_valid = v;
    endtask

    initial begin
        reset = 1'b1;
        point = 1'b0;
        clear = 1'b0;
        frame_start = 1'b0;
        set_pix(0, 0, 1'b0);

        // Reset state.
        #12;
        check("rst_tens", 32'(tens), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
        check("rst_max", 32'(max_reached), 32'd0);
        check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_sel", 32'(digit_sel), 32'd0);
        #8 reset = 1'b0;
        tick();

        // Increment and carry.
        for (int i = 0; i < 9; i++) pulse_point();
        check("inc9_ones", 32'(ones), 32'd9);
        check("inc9_tens", 32'(tens), 32'd0);
        pulse_point();
        check("carry_tens", 32'(tens), 32'd1);
        check("carry_ones", 32'(ones), 32'd0);
        check("carry_max", 32'(max_reached), 32'd0);

        // Reach 12 and latch it for display.
        pulse_point();
        pulse_point();
        pulse_frame();

        // Back-to-back addressing, latency and boundaries with disp=12.
        set_pix(285, 20, 1'b1);
        tick();
        check("a_sel", 32'(digit_sel), 32'd1);
        check("a_col", 32'(digit_col), 32'd5);
        check("a_row", 32'(digit_row), 32'd4);
        set_pix(296, 16, 1'b1);
        tick();
        check("a_rgb", 32'(rgb_out), 32'(rom_model(4'd1, 10'd4, 10'd5)));
        check("a_rgb_valid", 32'(rgb_valid), 32'd1);
        check("b_sel", 32'(digit_sel), 32'd2);
        check("b_col", 32'(digit_col), 32'd3);
        check("b_row", 32'(digit_row), 32'd0);
        set_pix(291, 16, 1'b1);
        tick();
        check("b_rgb", 32'(rgb_out), 32'(rom_model(4'd2, 10'd0, 10'd3)));
        check("gap_sel", 32'(digit_sel), 32'd0);
        set_pix(290, 31, 1'b1);
        tick();
        check("gap_rgb", 32'(rgb_out), 32'd0);
        check("gap_rgb_valid", 32'(rgb_valid), 32'd1);
        check("last_sel", 32'(digit_sel), 32'd1);
        check("last_col", 32'(digit_col), 32'd10);
        check("last_row", 32'(digit_row), 32'd15);
        set_pix(280, 32, 1'b1);
        tick();
        check("last_rgb", 32'(rgb_out), 32'(rom_model(4'd1, 10'd15, 10'd10)));
        check("below_sel", 32'(digit_sel), 32'd0);
        set_pix(0, 0, 1'b0);
        tick();
        check("below_rgb", 32'(rgb_out), 32'd0);
        check("below_rgb_valid", 32'(rgb_valid), 32'd1);
        tick();
        check("invalid_rgb", 32'(rgb_out), 32'd0);
        check("invalid_rgb_valid", 32'(rgb_valid), 32'd0);

        // Clear beats a simultaneous point.
        clear = 1'b1;
        point = 1'b1;
        tick();
        clear = 1'b0;
        point = 1'b0;
        check("clr_pt_tens", 32'(tens), 32'd0);
        check("clr_pt_ones", 32'(ones), 32'd0);

        // Saturation at 99.
        for (int i = 0; i < 98; i++) pulse_point();
        check("s98_ones", 32'(ones), 32'd8);
        check("s98_max", 32'(max_reached), 32'd0);
        pulse_point();
        check("s99_tens", 32'(tens), 32'd9);
        check("s99_ones", 32'(ones), 32'd9);
        check("s99_max", 32'(max_reached), 32'd1);
        pulse_point();
        check("sat_tens", 32'(tens), 32'd9);
        check("sat_ones", 32'(ones), 32'd9);
        check("sat_max", 32'(max_reached), 32'd1);

        // Leading-zero blanking with score 05.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_max", 32'(max_reached), 32'd0);
        for (int i = 0; i < 5; i++) pulse_point();
        pulse_frame();
        set_pix(285, 20, 1'b1);
        tick();
        check("blank_sel", 32'(digit_sel), 32'd0);
        set_pix(296, 16, 1'b1);
        tick();
        check("blank_rgb", 32'(rgb_out), 32'd0);
        check("blank_rgb_valid", 32'(rgb_valid), 32'd1);
        check("five_sel", 32'(digit_sel), 32'd5);
        set_pix(0, 0, 1'b0);
        tick();
        check("five_rgb", 32'(rgb_out), 32'(rom_model(4'd5, 10'd0, 10'd3)));

        // Mid-frame point does not reach the display until frame_start.
        pulse_point();
        check("mid_live_ones", 32'(ones), 32'd6);
        set_pix(296, 16, 1'b1);
        tick();
        check("mid_disp_sel", 32'(digit_sel), 32'd5);
        set_pix(0, 0, 1'b0);
        pulse_frame();
        set_pix(296, 16, 1'b1);
        tick();
        check("latched_sel", 32'(digit_sel), 32'd6);
        set_pix(0, 0, 1'b0);

        // frame_start with point latches the pre-increment value.
        frame_start = 1'b1;
        point = 1'b1;
        tick();
        frame_start = 1'b0;
        point = 1'b0;
        check("fs_pt_live", 32'(ones), 32'd7);
        set_pix(296, 16, 1'b1);
        tick();
        check("fs_pt_sel", 32'(digit_sel), 32'd6);

        // Asynchronous reset mid-stream.
        tick();
        check("pre_rst_valid", 32'(rgb_valid), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("arst_rgb_valid", 32'(rgb_valid), 32'd0);
        check("arst_rgb_out", 32'(rgb_out), 32'd0);
        check("arst_tens", 32'(tens), 32'd0);
        check("arst_ones", 32'(ones), 32'd0);
        check("arst_sel", 32'(digit_sel), 32'd0);
        #2 reset = 1'b0;
        tick();
        check("post_rst_valid1", 32'(rgb_valid), 32'd0);
        tick();
        check("post_rst_valid2", 32'(rgb_valid), 32'd1);
        check("post_rst_rgb", 32'(rgb_out), 32'(rom_model(4'd0, 10'd0, 10'd3)));
        set_pix(0, 0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_renderer.md
# score_renderer

Pixel-side reader for the score digit sprites. Keeps a two-digit BCD score, maps each incoming screen coordinate into a digit-local row/column, and drives the row/col/select lookup into the 11×16 digit sprite ROMs (Number0..Number9, behind a select mux). Returns the pipelined 3-bit pixel colour to the Pong video compositor. One instance exists per player.

## Interface
- X0, 10'd280: left screen column of the tens digit
- Y0, 10'd16: top screen row of both digits
- DIGIT_W, 11: sprite width in pixels
- DIGIT_H, 16: sprite height in pixels
- GAP, 2: blank columns between the tens and ones digits

Ports:
- clk  input  1  pixel clock; the only clock
- reset  input  1  asynchronous, active-high reset
- point  input  1  one-cycle pulse; adds one to the score
- clear  input  1  synchronous score clear
- frame_start  input  1  one-cycle pulse at pixel (0,0); latches the displayed score
- pixel_x  input  10  current screen column
- pixel_y  input  10  current screen row
- pixel_valid  input  1  coordinate is in the visible area
- digit_row  output  10  registered sprite row sent to the ROM
- digit_col  output  10  registered sprite column sent to the ROM
- digit_sel  output  4  registered digit 0–9 that selects the ROM
- digit_rgb  input  3  combinational ROM return for digit_row/col/sel
- rgb_out  output  3  composited score pixel
- rgb_valid  output  1  rgb_out corresponds to a valid pixel
- tens, ones  output  4 each  live BCD score
- max_reached  output  1  score is at 99

## Operation
- Score counter
  - Live BCD pair {tens, ones}.
  - point: ones+1. When ones = 9, ones→0 and tens+1.
  - Saturates at 99. A point at 99 is ignored and max_reached stays 1.
  - clear and point in the same cycle: clear wins, and the score becomes 00.
- Display latch
  - {disp_tens, disp_ones} load from the live score only on frame_start. This prevents tearing mid-frame.
  - If frame_start coincides with point, the display latches the pre-increment value.
- Geometry
  - The tens box is x∈[X0, X0+DIGIT_W) and y∈[Y0, Y0+DIGIT_H).
  - The ones box is the same box shifted right by DIGIT_W+GAP.
  - Local coordinates: col = pixel_x − box_left, row = pixel_y − Y0.
  - Comparisons use 10-bit unsigned values.
- Stage 1 (registered)
  - Inside a box with pixel_valid=1: digit_row/col = local coordinates, digit_sel = the digit for that box, hit = 1.
  - Otherwise: row/col/sel = 0 and hit = 0.
  - Leading-zero blanking: with disp_tens = 0, the tens box forces hit = 0. It still issues sel = 0.
- Stage 2 (registered)
  - rgb_out = hit ? digit_rgb : 3'b000.
  - rgb_valid follows the delayed pixel_valid.
  - digit_sel values 10–15 never occur.

## Timing
- Latency from a pixel_x/pixel_y sample to rgb_out is exactly 2 clk edges, at full throughput (one pixel per cycle).
- digit_rgb is sampled in the same cycle that stage-1 outputs are presented. The ROM path is combinational.
- The score updates 1 cycle after point or clear. max_reached is registered together with the score.
- Reset values (asynchronous): score 00, display 00, digit_row/col/sel 0, hit 0, rgb_out 000, rgb_valid 0, max_reached 0.
- Reset mid-frame: the pipeline empties immediately. The first valid output is 2 cycles after reset deasserts.
- pixel_valid = 0 yields rgb_out 000 and rgb_valid 0 two cycles later.

## Structure
- Shared package `score_pkg`: DIGIT_W/DIGIT_H defaults, BCD digit type (4 bits), rgb type (3 bits), RGB_BLACK constant.
- Sub-module `bcd_score_counter`: holds the point/clear/saturate logic and the tens/ones/max_reached outputs.
- The ROM mux (digit_sel → Number0..9) lives outside this block.

## Test plan
- Increment and carry: reset, then 9 point pulses → ones=9, tens=0. One more pulse → tens=1, ones=0, max_reached=0.
- Saturation and priority:
  - 99 point pulses → 99 and max_reached=1. A further point leaves 99.
  - clear and point in the same cycle → 00 next cycle.
- Addressing and latency, with disp=12 and X0=280, Y0=16:
  - Drive (285,20) → next cycle digit_sel=1, digit_col=5, digit_row=4. The following cycle rgb_out equals the model ROM value.
  - Drive (296,16) → digit_sel=2, col=3, row=0.
- Boundaries:
  - (291,16), the gap column → hit=0 and rgb_out=000.
  - (290,31) → last pixel of the tens sprite, col=10, row=15.
  - (280,32) → outside, rgb_out=000.
- Blanking and latch:
  - Score 05 → pixels in the tens box give rgb_out=000.
  - A point mid-frame → disp stays 05 until frame_start, then shows 06.
- Async reset: assert reset between clock edges mid-stream → rgb_valid and rgb_out go to 0 immediately, and the score becomes 00.
